// File: rtl/ad_trig_pkg.sv
// ---------------------------------------------------------------------------
// ad_trig_pkg
// Shared definitions for the AD-start trigger generator:
//   - state_e   : lock supervision FSM states
//   - DEF_*     : default parameter values used by ad_trig_gen / ad_trig_ch
// ---------------------------------------------------------------------------
package ad_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_DIV_W      = 16;
  localparam int DEF_IDX_W      = 16;
  localparam int DEF_PULSE_LEN  = 2;
  localparam int DEF_MIN_PERIOD = 16;

endpackage

// File: rtl/ad_trig_ch.sv
// ---------------------------------------------------------------------------
// ad_trig_ch
// One trigger channel: spreads div_q start pulses evenly over the measured
// phase period with a multiplier-free DDA accumulator, stretches each fire
// into a PULSE_LEN-cycle ad_start pulse, tracks the sample index and a sticky
// overrun flag.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sync_i       : accepted phase_valid (restart period, shadow divisor)
//   run_i        : DDA may advance this cycle (FSM staying in RUN)
//   clr_ovr_i    : clear sticky overrun (FSM in IDLE)
//   ch_en_i      : channel enable
//   ch_div_i     : pulses per period (sampled on sync_i)
//   period_i     : current shadowed phase period
//   ad_start_o   : AD start pulse
//   samp_idx_o   : index of the last trigger in the current period
//   overrun_o    : sticky overrun status
// ---------------------------------------------------------------------------
module ad_trig_ch
  import ad_trig_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_i,
  input  logic             run_i,
  input  logic             clr_ovr_i,
  input  logic             ch_en_i,
  input  logic [DIV_W-1:0] ch_div_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             ad_start_o,
  output logic [IDX_W-1:0] samp_idx_o,
  output logic             overrun_o
);

  localparam int S_W  = CNT_W + 1;
  localparam int PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovr_q, ovr_d;
  logic             start_q, start_d;
  logic [PC_W-1:0]  cnt_q, cnt_d;

  logic [S_W-1:0]   sum;
  logic [S_W-1:0]   rem;
  logic [S_W-1:0]   per_ext;
  logic             fire;

  // DDA step: one fire each time the accumulated divisor crosses the period.
  // The remainder is carried so fires land evenly; a remainder still >= the
  // period means more than one fire was due this cycle (div_q > period).
  always_comb begin
    div_d   = div_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    per_ext = {1'b0, period_i};
    sum     = {1'b0, acc_q} + S_W'(div_q);
    rem     = sum - per_ext;

    if (sync_i) begin
      // Sync wins over any DDA fire due in the same cycle: sample 0 only.
      div_d = ch_div_i;
      acc_d = '0;
      idx_d = '0;
      fire  = ch_en_i && (ch_div_i != '0);
    end else if (run_i && ch_en_i && (div_q != '0)) begin
      if (sum >= per_ext) begin
        fire  = 1'b1;
        idx_d = (&idx_q) ? idx_q : idx_q + IDX_W'(1);
        if (rem >= per_ext) begin
          ovr_d = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = rem[CNT_W-1:0];
        end
      end else begin
        acc_d = sum[CNT_W-1:0];
      end
    end else begin
      acc_d = '0;
    end

    // A fire during an active pulse is dropped and flagged, never stretched.
    if (fire && !start_q) begin
      start_d = 1'b1;
      cnt_d   = PC_W'(PULSE_LEN - 1);
    end else if (start_q) begin
      if (cnt_q == '0) begin
        start_d = 1'b0;
      end else begin
        cnt_d = cnt_q - PC_W'(1);
      end
    end
    if (fire && start_q) begin
      ovr_d = 1'b1;
    end

    if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ad_start_o = start_q;
  assign samp_idx_o = idx_q;
  assign overrun_o  = ovr_q;

endmodule

// File: rtl/ad_trig_gen.sv
// ---------------------------------------------------------------------------
// ad_trig_gen
// Multi-channel AD-start trigger generator slaved to the phase-detector
// period measurement. Holds the lock FSM, the shadowed period and the
// watchdog; each channel is an ad_trig_ch instance.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : global enable, low forces IDLE
//   phase_valid  : single-cycle strobe at each phase-detect edge
//   phase_cnt    : measured period, valid with phase_valid
//   ch_en        : per-channel enable
//   ch_div       : per-channel pulses per period, channel i at [i*DIV_W +: DIV_W]
//   ad_start     : AD start pulses
//   samp_idx     : per-channel index of last trigger, channel i at [i*IDX_W +: IDX_W]
//   locked       : high while in RUN
//   overrun      : per-channel sticky overrun
// ---------------------------------------------------------------------------
module ad_trig_gen
  import ad_trig_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int PULSE_LEN  = DEF_PULSE_LEN,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    phase_valid,
  input  logic [CNT_W-1:0]        phase_cnt,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ad_start,
  output logic [NUM_CH*IDX_W-1:0] samp_idx,
  output logic                    locked,
  output logic [NUM_CH-1:0]       overrun
);

  localparam int WD_W = CNT_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic             period_ok;
  logic             sync_evt;
  logic             wd_expire;
  logic             dda_run;
  logic             clr_ovr;

  assign period_ok = phase_valid && (phase_cnt >= CNT_W'(MIN_PERIOD));
  assign sync_evt  = en && period_ok &&
                     ((state_q == ST_WAIT_SYNC) || (state_q == ST_RUN));
  // wd_q counts cycles since the last sync, so it expires on the 2*P-th one.
  assign wd_expire = (wd_q >= ({p_q, 1'b0} - WD_W'(1)));

  // Lock FSM, period shadow and watchdog.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    wd_d    = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (period_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (phase_valid && !period_ok) begin
          state_d = ST_WAIT_SYNC;
        end else if (!phase_valid && wd_expire) begin
          state_d = ST_WAIT_SYNC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
    end

    if (sync_evt) begin
      p_d  = phase_cnt;
      wd_d = '0;
    end else if (state_q == ST_RUN) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      wd_q    <= wd_d;
    end
  end

  // The DDA advances only while RUN persists; the cycle that leaves RUN
  // already produces no new fires and clears the accumulators.
  assign dda_run = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign clr_ovr = (state_q == ST_IDLE);
  assign locked  = (state_q == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ad_trig_ch #(
      .CNT_W     (CNT_W),
      .DIV_W     (DIV_W),
      .IDX_W     (IDX_W),
      .PULSE_LEN (PULSE_LEN)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_i     (sync_evt),
      .run_i      (dda_run),
      .clr_ovr_i  (clr_ovr),
      .ch_en_i    (ch_en[i]),
      .ch_div_i   (ch_div[i*DIV_W +: DIV_W]),
      .period_i   (p_q),
      .ad_start_o (ad_start[i]),
      .samp_idx_o (samp_idx[i*IDX_W +: IDX_W]),
      .overrun_o  (overrun[i])
    );
  end

endmodule

// File: tb/tb_ad_trig_gen.sv
// ---------------------------------------------------------------------------
// tb_ad_trig_gen
// Directed bench for ad_trig_gen with default parameters. Channel setup for
// the steady-state periods: ch0 div 4, ch1 div 3, ch2 div 60 (overrun source),
// ch3 enabled with div 0 (must stay silent). Period is 100 clk.
// ---------------------------------------------------------------------------
module tb_ad_trig_gen;

  localparam int NVEC = 21;

  logic        clk;
  logic        rstN;
  logic        en;
  logic        phaseValid;
  logic [31:0] phaseCnt;
  logic [3:0]  chEn;
  logic [63:0] chDiv;
  logic [3:0]  adStart;
  logic [63:0] sampIdx;
  logic        locked;
  logic [3:0]  overrun;

  int checks;
  int errors;
  logic [3:0] prevStart;

  typedef struct {
    int         offset;
    logic [3:0] expStart;
    logic [15:0] expIdx0;
    logic [15:0] expIdx1;
    logic       expLocked;
  } vecT;

  vecT vecs [NVEC];

  ad_trig_gen dut (
    .clk         (clk),
    .rst_n       (rstN),
    .en          (en),
    .phase_valid (phaseValid),
    .phase_cnt   (phaseCnt),
    .ch_en       (chEn),
    .ch_div      (chDiv),
    .ad_start    (adStart),
    .samp_idx    (sampIdx),
    .locked      (locked),
    .overrun     (overrun)
  );

  // 100 MHz style clock, active on posedge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Hold phase_valid/phase_cnt for the current cycle, then step to 1 ns
  // after the next rising edge where outputs are sampled
  task automatic applyStimulus(input bit pv, input logic [31:0] cnt);
    phaseValid = pv;
    phaseCnt   = cnt;
    @(posedge clk);
    #1;
    phaseValid = 1'b0;
  endtask

  // One 100-cycle period starting with phase_valid; counts rising edges of
  // channels 0 and 1 and optionally checks the offset table
  task automatic runPeriod(input bit useTable, input int changeAt,
                           input logic [15:0] newDiv0,
                           output int rise0, output int rise1);
    rise0 = 0;
    rise1 = 0;
    for (int o = 1; o <= 100; o++) begin
      applyStimulus(o == 1, 32'd100);
      if (o == changeAt) chDiv[15:0] = newDiv0;
      if (adStart[0] && !prevStart[0]) rise0++;
      if (adStart[1] && !prevStart[1]) rise1++;
      prevStart = adStart;
      if (useTable) begin
        for (int v = 0; v < NVEC; v++) begin
          if (vecs[v].offset == o) begin
            checkOutput($sformatf("start@%0d", o), 64'(adStart & 4'b1011),
                        64'(vecs[v].expStart));
            checkOutput($sformatf("idx0@%0d", o), 64'(sampIdx[15:0]),
                        64'(vecs[v].expIdx0));
            checkOutput($sformatf("idx1@%0d", o), 64'(sampIdx[31:16]),
                        64'(vecs[v].expIdx1));
            checkOutput($sformatf("locked@%0d", o), 64'(locked),
                        64'(vecs[v].expLocked));
          end
        end
      end
    end
  endtask

  initial begin
    int r0;
    int r1;
    int quietHits;

    checks    = 0;
    errors    = 0;
    prevStart = '0;

    // offset = samples after the phase_valid cycle; ch0 fires 0,25,50,75
    // ch1 fires 0,34,67; pulses are 2 clk, visible from fire+1
    vecs[0]  = '{1,   4'b0011, 16'd0, 16'd0, 1'b1};
    vecs[1]  = '{2,   4'b0011, 16'd0, 16'd0, 1'b1};
    vecs[2]  = '{3,   4'b0000, 16'd0, 16'd0, 1'b1};
    vecs[3]  = '{25,  4'b0000, 16'd0, 16'd0, 1'b1};
    vecs[4]  = '{26,  4'b0001, 16'd1, 16'd0, 1'b1};
    vecs[5]  = '{27,  4'b0001, 16'd1, 16'd0, 1'b1};
    vecs[6]  = '{28,  4'b0000, 16'd1, 16'd0, 1'b1};
    vecs[7]  = '{34,  4'b0000, 16'd1, 16'd0, 1'b1};
    vecs[8]  = '{35,  4'b0010, 16'd1, 16'd1, 1'b1};
    vecs[9]  = '{36,  4'b0010, 16'd1, 16'd1, 1'b1};
    vecs[10] = '{37,  4'b0000, 16'd1, 16'd1, 1'b1};
    vecs[11] = '{51,  4'b0001, 16'd2, 16'd1, 1'b1};
    vecs[12] = '{52,  4'b0001, 16'd2, 16'd1, 1'b1};
    vecs[13] = '{53,  4'b0000, 16'd2, 16'd1, 1'b1};
    vecs[14] = '{68,  4'b0010, 16'd2, 16'd2, 1'b1};
    vecs[15] = '{69,  4'b0010, 16'd2, 16'd2, 1'b1};
    vecs[16] = '{70,  4'b0000, 16'd2, 16'd2, 1'b1};
    vecs[17] = '{76,  4'b0001, 16'd3, 16'd2, 1'b1};
    vecs[18] = '{77,  4'b0001, 16'd3, 16'd2, 1'b1};
    vecs[19] = '{78,  4'b0000, 16'd3, 16'd2, 1'b1};
    vecs[20] = '{100, 4'b0000, 16'd3, 16'd2, 1'b1};

    rstN       = 1'b0;
    en         = 1'b0;
    phaseValid = 1'b0;
    phaseCnt   = '0;
    chEn       = 4'b1111;
    chDiv      = {16'd0, 16'd60, 16'd3, 16'd4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_start", 64'(adStart), 64'd0);
    checkOutput("rst_locked", 64'(locked), 64'd0);
    checkOutput("rst_ovr", 64'(overrun), 64'd0);
    checkOutput("rst_idx", sampIdx, 64'd0);
    rstN = 1'b1;
    en   = 1'b1;

    // IDLE -> WAIT_SYNC; a short period in WAIT_SYNC is ignored
    applyStimulus(1'b0, 32'd0);
    checkOutput("wait_locked", 64'(locked), 64'd0);
    applyStimulus(1'b1, 32'd10);
    checkOutput("wait_short_locked", 64'(locked), 64'd0);
    checkOutput("wait_short_start", 64'(adStart), 64'd0);

    // Ten stable periods, table checked; exactly 4 / 3 pulses per period
    for (int p = 0; p < 10; p++) begin
      runPeriod(1'b1, 0, 16'd4, r0, r1);
      checkOutput($sformatf("rise0_p%0d", p), 64'(r0), 64'd4);
      checkOutput($sformatf("rise1_p%0d", p), 64'(r1), 64'd3);
    end
    checkOutput("ovr_after_10", 64'(overrun), 64'b0100);

    // Divisor change mid-period applies from the next period only
    runPeriod(1'b0, 40, 16'd8, r0, r1);
    checkOutput("div_chg_cur", 64'(r0), 64'd4);
    runPeriod(1'b0, 0, 16'd8, r0, r1);
    checkOutput("div_chg_next", 64'(r0), 64'd8);
    checkOutput("div_chg_ch1", 64'(r1), 64'd3);

    // Watchdog: no phase_valid, locked falls 200 clk after the last sync
    quietHits = 0;
    for (int o = 101; o <= 260; o++) begin
      applyStimulus(1'b0, 32'd100);
      if (o == 200) checkOutput("wd_locked_200", 64'(locked), 64'd1);
      if (o == 201) checkOutput("wd_locked_201", 64'(locked), 64'd0);
      if (o >= 203 && adStart != 4'b0000) quietHits++;
    end
    checkOutput("wd_quiet", 64'(quietHits), 64'd0);

    // Relock on the first strobe
    applyStimulus(1'b1, 32'd100);
    checkOutput("relock_locked", 64'(locked), 64'd1);
    checkOutput("relock_start", 64'(adStart[1:0]), 64'b11);

    // Short period while in RUN drops lock, no further pulses
    repeat (9) applyStimulus(1'b0, 32'd100);
    applyStimulus(1'b1, 32'd10);
    checkOutput("short_locked", 64'(locked), 64'd0);
    quietHits = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 32'd100);
      if (adStart != 4'b0000) quietHits++;
    end
    checkOutput("short_quiet", 64'(quietHits), 64'd0);
    applyStimulus(1'b1, 32'd10);
    checkOutput("short_wait_locked", 64'(locked), 64'd0);
    checkOutput("ovr_sticky", 64'(overrun), 64'b0100);

    // en low clears overrun
    en = 1'b0;
    repeat (2) applyStimulus(1'b0, 32'd100);
    checkOutput("en_low_ovr", 64'(overrun), 64'd0);
    checkOutput("en_low_locked", 64'(locked), 64'd0);

    // Relock, then async reset in the middle of a ch0 pulse
    chDiv[15:0] = 16'd4;
    en = 1'b1;
    applyStimulus(1'b0, 32'd100);
    for (int o = 1; o <= 27; o++) applyStimulus(o == 1, 32'd100);
    checkOutput("pre_rst_start0", 64'(adStart[0]), 64'd1);
    checkOutput("pre_rst_idx0", 64'(sampIdx[15:0]), 64'd1);
    checkOutput("pre_rst_ovr2", 64'(overrun[2]), 64'd1);
    checkOutput("pre_rst_locked", 64'(locked), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_start", 64'(adStart), 64'd0);
    checkOutput("async_rst_locked", 64'(locked), 64'd0);
    checkOutput("async_rst_ovr", 64'(overrun), 64'd0);
    checkOutput("async_rst_idx", sampIdx, 64'd0);
    #20;
    rstN = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_trig_gen.md
Name: ad_trig_gen

Overview:
- Multi-channel AD-start trigger generator, slaved to the phase-detector period measurement.
- Each channel emits exactly ch_div start pulses per measured phase period, evenly spread using a multiplier-free DDA accumulator.
- Pulses are resynchronised on every phase_valid. Lock supervision, per-channel sample index and sticky overrun status are provided.
- Sits between the phase-measurement block and the AD front-end interfaces.

Parameters:
- NUM_CH, 4, number of independent trigger channels.
- CNT_W, 32, width of phase period count (clk cycles).
- DIV_W, 16, width of per-channel samples-per-period divisor.
- IDX_W, 16, width of per-channel sample index.
- PULSE_LEN, 2, ad_start high time in clk cycles (>=1).
- MIN_PERIOD, 16, smallest phase_cnt accepted as valid.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable (register reg_ad_enble); low forces IDLE.
- phase_valid  in  1  single-cycle strobe at each phase-detect edge.
- phase_cnt  in  CNT_W  measured period, valid with phase_valid.
- ch_en  in  NUM_CH  per-channel enable.
- ch_div  in  NUM_CH*DIV_W  per-channel samples per period; channel i at [i*DIV_W +: DIV_W].
- ad_start  out  NUM_CH  AD start pulses.
- samp_idx  out  NUM_CH*IDX_W  index of the last trigger within the current period.
- locked  out  1  high while in RUN.
- overrun  out  NUM_CH  sticky; cleared by en low or reset.

Behaviour:
- Reset (async): all outputs 0, all accumulators 0, FSM=IDLE, shadow period/divisors 0.
- FSM states: IDLE, WAIT_SYNC, RUN. The state register is shared; per-channel datapaths are separate.
  - IDLE: entered when en=0 (from any state, next cycle). Leaves to WAIT_SYNC when en=1.
  - WAIT_SYNC: on phase_valid with phase_cnt>=MIN_PERIOD, go to RUN. phase_valid with a short period is ignored.
  - RUN: phase_valid with a short period goes to WAIT_SYNC. Watchdog: if no phase_valid for 2*P_q cycles, go to WAIT_SYNC. locked=1 only in RUN.
- Sync event = accepted phase_valid. On a sync event:
  - P_q<=phase_cnt, div_q[i]<=ch_div[i] (shadowed, so config changes apply at the next period only).
  - acc[i]<=0, samp_idx[i]<=0, watchdog<=0.
  - Channel fires (sample 0) if ch_en[i] and ch_div[i]!=0.
- RUN, non-sync cycle, per channel with ch_en[i] and div_q[i]!=0:
  - s=acc+div_q (width CNT_W+1).
  - If s>=P_q: fire, acc<=s-P_q, samp_idx saturating +1.
  - Else acc<=s.
  - If s-P_q>=P_q (div_q>P_q): fire, set overrun[i], acc<=0.
  - Result: exactly div_q fires per period when div_q<=P_q and the period is stable.
- Disabled channel (ch_en=0 or div_q=0): acc held 0, no fires, samp_idx held.
- Pulse: ad_start[i] rises 1 clk after the fire cycle (registered) and stays high PULSE_LEN cycles.
  - A fire while the pulse is still active does not extend or restart it and sets overrun[i].
- Leaving RUN (en low, watchdog, short period):
  - Pulses in flight complete their length.
  - No new fires; acc cleared.
  - samp_idx holds until the next sync.
- overrun: sticky; cleared only in IDLE or by reset.
- Simultaneous phase_valid and DDA fire: the sync fire takes priority; one fire only.

Decomposition:
- Package ad_trig_pkg: FSM state enum (ST_IDLE, ST_WAIT_SYNC, ST_RUN) and default parameter constants.
- Sub-module ad_trig_ch, instantiated NUM_CH times in a generate loop. It contains the accumulator, divisor shadow, fire logic, pulse counter, samp_idx and overrun.
- The top holds the FSM, P_q and the watchdog.

Test Plan:
- en=1, phase_valid every 100 clk (phase_cnt=100), ch_div[0]=4 -> after first sync, ad_start[0] rises at offsets 1,26,51,76 after each phase_valid, each 2 clk wide; samp_idx 0..3; locked=1.
- ch_div[1]=3, P=100 -> fires at sync cycle and +34, +67; exactly 3 per period over 10 periods; overrun=0.
- ch_div[2]=60, P=100, PULSE_LEN=2 -> fires closer than 2 cycles occur; overrun[2] set and stays set until en dropped.
- Stop phase_valid after lock at P=100 -> locked falls 200 clk after the last sync, ad_start quiet. Resume phase_valid -> relock on the first strobe.
- Change ch_div[0] 4->8 mid-period -> current period still yields 4 pulses, next yields 8. phase_cnt=10 (<MIN_PERIOD) in RUN -> WAIT_SYNC, no pulses.
- Assert rst_n low mid-pulse -> ad_start, locked, overrun, samp_idx all 0 immediately (async).
